alu_operand_loader: RTL and testbench

- Upstream stage for the 8-bit ALU. The 8-bit input pad bus cannot carry A, B and the selector at once, so this block captures them serially over one byte port using a pad-driven load strobe.
- Once all three are captured, it issues them to the ALU as registered operands and captures the ALU result into a held output register with a valid flag.
- It sits between the top-level pad wrapper and the ALU instance.

---
 rtl/alu_operand_loader.sv | 115 +++++++++++
 tb/tb_alu_operand_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Serial operand loader for the 8-bit ALU: captures A, B and the selector over one
// byte bus on synchronized strobe edges, issues them, then holds the ALU result.
module alu_operand_loader #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_stb,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_s,
  output logic             alu_go,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] res_out,
  output logic             res_valid,
  output logic             busy,
  output logic [2:0]       phase
);

  localparam logic [2:0] LD_A  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_OP = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic       ld_s1_reg, ld_s2_reg, ld_prev_reg;
  logic       ab_s1_reg, ab_s2_reg;
  logic [2:0] state_reg;
  logic [3:0] cnt_reg;
  logic       go_reg;
  logic       stb_edge;

  // Pad inputs are asynchronous; the prev flop runs regardless of ena so that a
  // strobe seen while disabled is consumed rather than replayed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_s1_reg   <= 1'b0;
      ld_s2_reg   <= 1'b0;
      ld_prev_reg <= 1'b0;
      ab_s1_reg   <= 1'b0;
      ab_s2_reg   <= 1'b0;
    end else begin
      ld_s1_reg   <= ld_stb;
      ld_s2_reg   <= ld_s1_reg;
      ld_prev_reg <= ld_s2_reg;
      ab_s1_reg   <= abort;
      ab_s2_reg   <= ab_s1_reg;
    end
  end

  assign stb_edge = ld_s2_reg & ~ld_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LD_A;
      cnt_reg   <= 4'd0;
      go_reg    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
    end else if (ab_s2_reg) begin
      state_reg <= LD_A;
      go_reg    <= 1'b0;
      res_valid <= 1'b0;
    end else if (ena) begin
      go_reg <= 1'b0;
      case (state_reg)
        LD_A, DONE: begin
          if (stb_edge) begin
            alu_a     <= data_in;
            res_valid <= 1'b0;
            state_reg <= LD_B;
          end
        end
        LD_B: begin
          if (stb_edge) begin
            alu_b     <= data_in;
            state_reg <= LD_OP;
          end
        end
        LD_OP: begin
          if (stb_edge) begin
            alu_s     <= data_in[SEL_W-1:0];
            cnt_reg   <= 4'(LAT);
            go_reg    <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // Strobes arriving here are dropped; operands stay frozen until DONE.
          if (cnt_reg == 4'd0) begin
            res_out   <= alu_result;
            res_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= LD_A;
      endcase
    end
  end

  assign alu_go = go_reg;
  assign busy   = (state_reg == EXEC);
  assign phase  = state_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Drives two loaders (LAT=0 and LAT=3) with the same pad stimulus and checks them
// every cycle against a transaction-level model indexed by absolute edge number.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n, ena, ld_stb, abort;
  logic [7:0] data_in;

  logic [7:0] a_o[2], b_o[2], r_o[2], res_in[2];
  logic [1:0] s_o[2];
  logic       go_o[2], v_o[2], busy_o[2];
  logic [2:0] ph_o[2];

  int n_chk = 0, n_fail = 0;
  int go_cnt[2], busy_cnt[2];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] s);
    case (s)
      2'd0:    return a ^ b;
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return a & b;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      alu_operand_loader #(.WIDTH(8), .SEL_W(2), .LAT(gi * 3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
        .ld_stb(ld_stb), .abort(abort),
        .alu_a(a_o[gi]), .alu_b(b_o[gi]), .alu_s(s_o[gi]), .alu_go(go_o[gi]),
        .alu_result(res_in[gi]), .res_out(r_o[gi]), .res_valid(v_o[gi]),
        .busy(busy_o[gi]), .phase(ph_o[gi])
      );
      assign res_in[gi] = alu_f(a_o[gi], b_o[gi], s_o[gi]);
    end
  endgenerate

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: a strobe sampled high at edge k (low at k-1) acts at edge k+2;
  // an abort sample at edge k acts at edge k+2. EXEC entered at edge E completes at E+1+LAT.
  int         m_ph[2], m_done[2], n;
  logic [7:0] m_a[2], m_b[2], m_r[2];
  logic [1:0] m_s[2];
  logic       m_go[2], m_v[2];
  logic       l1, l2, l3, a1, a2, stb, ab;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_a[i] = 0; m_b[i] = 0; m_s[i] = 0; m_r[i] = 0;
        m_go[i] = 0; m_v[i] = 0; m_done[i] = 0;
      end
      {l1, l2, l3, a1, a2} = '0;
      n = 0;
    end else begin
      stb = l2 & ~l3;
      ab  = a2;
      n++;
      for (int i = 0; i < 2; i++) begin
        if (ab) begin
          m_ph[i] = 0; m_go[i] = 0; m_v[i] = 0;
        end else if (ena) begin
          m_go[i] = 0;
          if ((m_ph[i] == 0 || m_ph[i] == 4) && stb) begin
            m_a[i] = data_in; m_v[i] = 0; m_ph[i] = 1;
          end else if (m_ph[i] == 1 && stb) begin
            m_b[i] = data_in; m_ph[i] = 2;
          end else if (m_ph[i] == 2 && stb) begin
            m_s[i] = data_in[1:0]; m_ph[i] = 3; m_go[i] = 1;
            m_done[i] = n + 1 + i * 3;
          end else if (m_ph[i] == 3 && n == m_done[i]) begin
            m_r[i] = alu_f(m_a[i], m_b[i], m_s[i]); m_v[i] = 1; m_ph[i] = 4;
          end
        end else if (m_ph[i] == 3) begin
          m_done[i]++;
        end
      end
      l3 = l2; l2 = l1; l1 = ld_stb;
      a2 = a1; a1 = abort;
    end
  end

  // Per-cycle compare; during reset everything must read zero.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_a", i, a_o[i], 0);      chk("rst_b", i, b_o[i], 0);
        chk("rst_s", i, s_o[i], 0);      chk("rst_res", i, r_o[i], 0);
        chk("rst_go", i, go_o[i], 0);    chk("rst_valid", i, v_o[i], 0);
        chk("rst_busy", i, busy_o[i], 0); chk("rst_phase", i, ph_o[i], 0);
      end else begin
        chk("alu_a", i, a_o[i], m_a[i]);   chk("alu_b", i, b_o[i], m_b[i]);
        chk("alu_s", i, s_o[i], m_s[i]);   chk("res_out", i, r_o[i], m_r[i]);
        chk("alu_go", i, go_o[i], m_go[i]); chk("res_valid", i, v_o[i], m_v[i]);
        chk("busy", i, busy_o[i], m_ph[i] == 3); chk("phase", i, ph_o[i], m_ph[i]);
      end
      go_cnt[i]   += int'(go_o[i]);
      busy_cnt[i] += int'(busy_o[i]);
    end
  end

  task automatic strobe(input logic [7:0] d, input int hold, input int gap);
    data_in = d;
    ld_stb  = 1'b1;
    repeat (hold) @(negedge clk);
    ld_stb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      go_cnt[i] = 0; busy_cnt[i] = 0;
    end
  endtask

  task automatic abort_pulse(input int len);
    abort = 1'b1;
    repeat (len) @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; ld_stb = 1'b0; abort = 1'b0; data_in = 8'h00;
    clr_cnt();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lit_reset_phase", i, ph_o[i], 0);

    // Full transaction: 0x12 + 0x34 with selector 1.
    clr_cnt();
    strobe(8'h12, 3, 3); strobe(8'h34, 3, 3); strobe(8'h01, 3, 3);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("lit_a", i, a_o[i], 8'h12);  chk("lit_b", i, b_o[i], 8'h34);
      chk("lit_s", i, s_o[i], 2'b01);  chk("lit_res", i, r_o[i], 8'h46);
      chk("lit_valid", i, v_o[i], 1);  chk("lit_phase", i, ph_o[i], 4);
      chk("lit_go_cnt", i, go_cnt[i], 1);
    end
    chk("lit_busy_cycles", 0, busy_cnt[0], 1);
    chk("lit_busy_cycles", 1, busy_cnt[1], 4);

    // Back-to-back from DONE; old result retained until the next capture.
    strobe(8'h05, 3, 3);
    for (int i = 0; i < 2; i++) begin
      chk("lit_b2b_a", i, a_o[i], 8'h05); chk("lit_b2b_valid", i, v_o[i], 0);
      chk("lit_b2b_res", i, r_o[i], 8'h46);
    end
    strobe(8'h07, 3, 3);
    // Second strobe pulse lands in LAT=3 EXEC (dropped) but in LAT=0 DONE (captured).
    clr_cnt();
    data_in = 8'h02; ld_stb = 1'b1; @(negedge clk);
    ld_stb = 1'b0; @(negedge clk);
    ld_stb = 1'b1; @(negedge clk);
    ld_stb = 1'b0; @(negedge clk);
    @(negedge clk);
    chk("lit_exec_phase", 1, ph_o[1], 3);
    chk("lit_exec_a", 1, a_o[1], 8'h05);
    repeat (5) @(negedge clk);
    chk("lit_drop_phase", 1, ph_o[1], 4); chk("lit_drop_a", 1, a_o[1], 8'h05);
    chk("lit_drop_res", 1, r_o[1], 8'hFE); chk("lit_drop_go", 1, go_cnt[1], 1);
    chk("lit_done_a", 0, a_o[0], 8'h02); chk("lit_done_phase", 0, ph_o[0], 1);
    abort_pulse(4);

    // Abort in LD_OP, with a strobe while abort is high.
    strobe(8'h11, 3, 3); strobe(8'h22, 3, 3);
    clr_cnt();
    abort = 1'b1; @(negedge clk);
    strobe(8'h77, 3, 3);
    for (int i = 0; i < 2; i++) begin
      chk("lit_abort_phase", i, ph_o[i], 0); chk("lit_abort_valid", i, v_o[i], 0);
    end
    abort = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lit_abort_go", i, go_cnt[i], 0);
    strobe(8'h30, 3, 3); strobe(8'h0F, 3, 3); strobe(8'h00, 3, 3);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lit_post_abort_res", i, r_o[i], 8'h3F);

    // Held strobe produces one capture; selector keeps only its low bits.
    strobe(8'hAA, 20, 3);
    for (int i = 0; i < 2; i++) begin
      chk("lit_held_a", i, a_o[i], 8'hAA); chk("lit_held_phase", i, ph_o[i], 1);
    end
    strobe(8'hBB, 3, 3); strobe(8'hFF, 3, 3);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("lit_sel_ff", i, s_o[i], 2'b11); chk("lit_and_res", i, r_o[i], 8'hAA);
    end

    // Strobe while disabled is discarded.
    strobe(8'h40, 3, 3);
    ena = 1'b0;
    strobe(8'h99, 3, 3);
    ena = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_ena_b", i, b_o[i], 8'hBB); chk("lit_ena_phase", i, ph_o[i], 1);
    end
    strobe(8'h01, 3, 3); strobe(8'h03, 3, 3);
    repeat (6) @(negedge clk);

    // Randomized traffic; the per-cycle model does the checking.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 19) == 0) begin
        abort_pulse($urandom_range(1, 4));
      end else begin
        ena = ($urandom_range(0, 9) != 0);
        strobe(8'($urandom), $urandom_range(1, 4), $urandom_range(2, 4));
        ena = 1'b1;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end

    // Async reset mid-EXEC.
    abort_pulse(3);
    strobe(8'h01, 3, 3); strobe(8'h02, 3, 3);
    data_in = 8'h03; ld_stb = 1'b1;
    for (int t = 0; t < 20 && !busy_o[1]; t++) @(negedge clk);
    chk("exec_wait", 1, busy_o[1], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_async_a", i, a_o[i], 0);   chk("lit_async_res", i, r_o[i], 0);
      chk("lit_async_busy", i, busy_o[i], 0); chk("lit_async_phase", i, ph_o[i], 0);
      chk("lit_async_valid", i, v_o[i], 0);
    end
    ld_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(8'h5A, 3, 3);
    for (int i = 0; i < 2; i++) begin
      chk("lit_after_rst_a", i, a_o[i], 8'h5A); chk("lit_after_rst_phase", i, ph_o[i], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
